// File: rtl/uc_jogo_pkg.sv
// uc_jogo_pkg
// Shared definitions for the round-based ("siga a musica") game controller.
//   EST_W        : width of the state register
//   estado_t     : state codes, numbered in sequence order
//   erro_jogada(): decides whether the note just played counts as an error
package uc_jogo_pkg;

   localparam int EST_W = 5;

   typedef enum logic [EST_W-1:0] {
      INICIAL       = 5'd0,
      PREPARA       = 5'd1,
      INICIA_RODADA = 5'd2,
      MOSTRA        = 5'd3,
      FIM_MOSTRA    = 5'd4,
      PROX_MOSTRA   = 5'd5,
      INICIA_JOGADA = 5'd6,
      ESPERA_JOGADA = 5'd7,
      REGISTRA      = 5'd8,
      COMPARA       = 5'd9,
      FEEDBACK_OK   = 5'd10,
      FEEDBACK_ERRO = 5'd11,
      FIM_JOGADA    = 5'd12,
      PROX_JOGADA   = 5'd13,
      FIM_RODADA    = 5'd14,
      PROX_RODADA   = 5'd15,
      GANHOU        = 5'd16,
      PERDEU        = 5'd17,
      TIMEOUT       = 5'd18
   } estado_t;

   // Wrong pitch is always an error; wrong tempo only when tempo checking is on.
   function automatic logic erro_jogada(input logic nota_correta,
                                        input logic checa_tempo,
                                        input logic tempo_correto);
      return ~nota_correta | (checa_tempo & ~tempo_correto);
   endfunction

endpackage

// File: rtl/uc_contador_erros.sv
// uc_contador_erros
// Saturating error counter.
//   clock, reset : clock, async active-high reset
//   clr_i        : synchronous clear (wins over inc_i)
//   inc_i        : add one, holding at MAX
//   cnt_o        : current count
//   limite_o     : registered flag, high when one more increment reaches MAX,
//                  so the FSM can decide "lost" in the same cycle it counts.
module uc_contador_erros #(
   parameter int MAX = 3,
   parameter int W   = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         limite_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         limite_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != W'(MAX)))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         limite_q <= (MAX == 1);
      end else begin
         cnt_q    <= cnt_d;
         limite_q <= (cnt_d == W'(MAX - 1));
      end
   end

   assign cnt_o    = cnt_q;
   assign limite_o = limite_q;

endmodule

// File: rtl/uc_jogo_rodadas.sv
// uc_jogo_rodadas
// Moore FSM sequencing the FPGAudio datapath in round-based mode: round N
// plays stored notes 0..N, then the player repeats them with pitch (and
// optionally tempo) checked. Tracks errors, timeout and end of song.
//   clock, reset          : clock, async active-high reset
//   iniciar               : start pulse (only honoured in INICIAL)
//   cancela               : synchronous abort to INICIAL, highest priority
//   checa_tempo           : count right-pitch/wrong-tempo notes as errors
//   nota_feita .. press_enter : datapath condition inputs
//   zeraC .. registra_erro    : datapath control strobes
//   pronto/ganhou/perdeu/timeout : game status
//   erros_cnt             : errors so far
//   db_estado             : current state code
module uc_jogo_rodadas
   import uc_jogo_pkg::*;
#(
   parameter int MAX_ERROS = 3,
   parameter int ESTADO_W  = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic                cancela,
   input  logic                checa_tempo,
   input  logic                nota_feita,
   input  logic                nota_correta,
   input  logic                tempo_correto,
   input  logic                enderecoIgualRodada,
   input  logic                fimTF,
   input  logic                fimTempo,
   input  logic                fimCR,
   input  logic                fim_musica,
   input  logic                press_enter,
   output logic                zeraC,
   output logic                contaC,
   output logic                zeraCR,
   output logic                contaCR,
   output logic                zeraR,
   output logic                registraR,
   output logic                zeraTF,
   output logic                contaTF,
   output logic                zeraTempo,
   output logic                contaTempo,
   output logic                zeraMetro,
   output logic                contaMetro,
   output logic                leds_mem,
   output logic                ativa_leds,
   output logic                toca,
   output logic                registra_erro,
   output logic                pronto,
   output logic                ganhou,
   output logic                perdeu,
   output logic                timeout,
   output logic [2:0]          erros_cnt,
   output logic [ESTADO_W-1:0] db_estado
);

   estado_t state_q, state_d;
   logic    erro;
   logic    limite;

   assign erro = erro_jogada(nota_correta, checa_tempo, tempo_correto);

   // limite is registered from the count, so it is valid in COMPARA and tells
   // whether this error is the one that exhausts the budget.
   uc_contador_erros #(.MAX(MAX_ERROS), .W(3)) u_erros (
      .clock   (clock),
      .reset   (reset),
      .clr_i   (state_q == PREPARA),
      .inc_i   ((state_q == COMPARA) && erro),
      .cnt_o   (erros_cnt),
      .limite_o(limite)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         INICIAL:       if (iniciar) state_d = PREPARA;
         PREPARA:       state_d = INICIA_RODADA;
         INICIA_RODADA: state_d = MOSTRA;
         MOSTRA:        if (fimTF) state_d = FIM_MOSTRA;
         FIM_MOSTRA:    state_d = enderecoIgualRodada ? INICIA_JOGADA : PROX_MOSTRA;
         PROX_MOSTRA:   state_d = MOSTRA;
         INICIA_JOGADA: state_d = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            // a keypress in the same cycle as the time limit still counts
            if (nota_feita)    state_d = REGISTRA;
            else if (fimTempo) state_d = TIMEOUT;
         end
         REGISTRA:      state_d = COMPARA;
         COMPARA: begin
            if (erro) state_d = limite ? PERDEU : FEEDBACK_ERRO;
            else      state_d = FEEDBACK_OK;
         end
         // feedback is held while the key is still down, so a long press
         // is not taken as the next note
         FEEDBACK_OK:   if (fimTF && !nota_feita) state_d = FIM_JOGADA;
         // INICIA_RODADA provides the timer clear and replays the same round
         FEEDBACK_ERRO: if (fimTF && !nota_feita) state_d = INICIA_RODADA;
         FIM_JOGADA:    state_d = enderecoIgualRodada ? FIM_RODADA : PROX_JOGADA;
         PROX_JOGADA:   state_d = ESPERA_JOGADA;
         FIM_RODADA:    state_d = (fim_musica || fimCR) ? GANHOU : PROX_RODADA;
         PROX_RODADA:   state_d = INICIA_RODADA;
         GANHOU, PERDEU, TIMEOUT: if (press_enter) state_d = INICIAL;
         default:       state_d = INICIAL;
      endcase
      if (cancela) state_d = INICIAL;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= INICIAL;
      else       state_q <= state_d;
   end

   // Moore output decode
   always_comb begin
      zeraC = 1'b0;  contaC = 1'b0;  zeraCR = 1'b0;  contaCR = 1'b0;
      zeraR = 1'b0;  registraR = 1'b0;  zeraTF = 1'b0;  contaTF = 1'b0;
      zeraTempo = 1'b0;  contaTempo = 1'b0;  zeraMetro = 1'b0;  contaMetro = 1'b0;
      leds_mem = 1'b0;  ativa_leds = 1'b0;  toca = 1'b0;  registra_erro = 1'b0;
      pronto = 1'b0;  ganhou = 1'b0;  perdeu = 1'b0;  timeout = 1'b0;
      case (state_q)
         PREPARA: begin
            zeraC = 1'b1;  zeraCR = 1'b1;  zeraR = 1'b1;
            zeraMetro = 1'b1;  zeraTempo = 1'b1;  zeraTF = 1'b1;
         end
         INICIA_RODADA: begin zeraC = 1'b1;  zeraTF = 1'b1; end
         MOSTRA: begin
            leds_mem = 1'b1;  ativa_leds = 1'b1;  toca = 1'b1;  contaTF = 1'b1;
         end
         FIM_MOSTRA:    zeraTF = 1'b1;
         PROX_MOSTRA:   contaC = 1'b1;
         INICIA_JOGADA: begin zeraC = 1'b1;  zeraTempo = 1'b1;  zeraMetro = 1'b1; end
         ESPERA_JOGADA: begin registraR = 1'b1;  contaTempo = 1'b1;  contaMetro = 1'b1; end
         REGISTRA:      begin registraR = 1'b1;  contaMetro = 1'b1; end
         COMPARA:       begin registra_erro = 1'b1;  contaMetro = 1'b1; end
         FEEDBACK_OK:   begin ativa_leds = 1'b1;  toca = 1'b1;  contaTF = 1'b1; end
         FEEDBACK_ERRO: begin ativa_leds = 1'b1;  contaTF = 1'b1; end
         FIM_JOGADA:    begin zeraTF = 1'b1;  zeraTempo = 1'b1; end
         PROX_JOGADA:   begin contaC = 1'b1;  zeraMetro = 1'b1; end
         PROX_RODADA:   contaCR = 1'b1;
         GANHOU:        begin pronto = 1'b1;  ganhou = 1'b1; end
         PERDEU:        begin pronto = 1'b1;  perdeu = 1'b1; end
         TIMEOUT:       begin pronto = 1'b1;  timeout = 1'b1; end
         default: ;
      endcase
   end

   assign db_estado = ESTADO_W'(state_q);

endmodule

// File: tb/tb_uc_jogo_rodadas.sv
`timescale 1ns/1ps
module tb_uc_jogo_rodadas;

   localparam int MAXE = 3;
   localparam int S_INICIAL = 0,  S_PREPARA = 1,  S_IR = 2,  S_MOSTRA = 3,
                  S_FIM_MOSTRA = 4, S_PROX_MOSTRA = 5, S_IJ = 6, S_ESPERA = 7,
                  S_REGISTRA = 8, S_COMPARA = 9, S_FB_OK = 10, S_FB_ERRO = 11,
                  S_FIM_JOGADA = 12, S_PROX_JOGADA = 13, S_FIM_RODADA = 14,
                  S_PROX_RODADA = 15, S_GANHOU = 16, S_PERDEU = 17, S_TIMEOUT = 18;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic iniciar = 0, cancela = 0, checa_tempo = 0, nota_feita = 0, nota_correta = 1,
         tempo_correto = 1, enderecoIgualRodada = 0, fimTF = 0, fimTempo = 0, fimCR = 0,
         fim_musica = 0, press_enter = 0;
   logic zeraC, contaC, zeraCR, contaCR, zeraR, registraR, zeraTF, contaTF, zeraTempo,
         contaTempo, zeraMetro, contaMetro, leds_mem, ativa_leds, toca, registra_erro,
         pronto, ganhou, perdeu, timeout;
   logic [2:0]  erros_cnt;
   logic [4:0]  db_estado;
   logic [19:0] outs;

   uc_jogo_rodadas #(.MAX_ERROS(MAXE), .ESTADO_W(5)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .cancela(cancela),
      .checa_tempo(checa_tempo), .nota_feita(nota_feita), .nota_correta(nota_correta),
      .tempo_correto(tempo_correto), .enderecoIgualRodada(enderecoIgualRodada),
      .fimTF(fimTF), .fimTempo(fimTempo), .fimCR(fimCR), .fim_musica(fim_musica),
      .press_enter(press_enter),
      .zeraC(zeraC), .contaC(contaC), .zeraCR(zeraCR), .contaCR(contaCR), .zeraR(zeraR),
      .registraR(registraR), .zeraTF(zeraTF), .contaTF(contaTF), .zeraTempo(zeraTempo),
      .contaTempo(contaTempo), .zeraMetro(zeraMetro), .contaMetro(contaMetro),
      .leds_mem(leds_mem), .ativa_leds(ativa_leds), .toca(toca),
      .registra_erro(registra_erro), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
      .timeout(timeout), .erros_cnt(erros_cnt), .db_estado(db_estado)
   );

   assign outs = {zeraC, contaC, zeraCR, contaCR, zeraR, registraR, zeraTF, contaTF,
                  zeraTempo, contaTempo, zeraMetro, contaMetro, leds_mem, ativa_leds,
                  toca, registra_erro, pronto, ganhou, perdeu, timeout};

   always #5 clock = ~clock;

   // monitor: counts round-counter increments and note-display cycles
   int ncr = 0, nmostra = 0;
   always @(negedge clock) if (!reset) begin
      if (contaCR)  ncr++;
      if (leds_mem) nmostra++;
   end

   typedef struct {string tag; int st; int errs;} exp_t;
   exp_t sb[$];
   int vectors = 0, miscompares = 0;

   // expected Moore outputs per state, written from the state table
   function automatic logic [19:0] exp_outs(int s);
      logic zc, cc, zcr, ccr, zr, rr, ztf, ctf, zt, ct, zm, cm, lm, al, to, re, pr, g, p, tmo;
      {zc, cc, zcr, ccr, zr, rr, ztf, ctf, zt, ct, zm, cm, lm, al, to, re, pr, g, p, tmo} = '0;
      case (s)
         S_PREPARA:     begin zc = 1; zcr = 1; zr = 1; zm = 1; zt = 1; ztf = 1; end
         S_IR:          begin zc = 1; ztf = 1; end
         S_MOSTRA:      begin lm = 1; al = 1; to = 1; ctf = 1; end
         S_FIM_MOSTRA:  ztf = 1;
         S_PROX_MOSTRA: cc = 1;
         S_IJ:          begin zc = 1; zt = 1; zm = 1; end
         S_ESPERA:      begin rr = 1; ct = 1; cm = 1; end
         S_REGISTRA:    begin rr = 1; cm = 1; end
         S_COMPARA:     begin re = 1; cm = 1; end
         S_FB_OK:       begin al = 1; to = 1; ctf = 1; end
         S_FB_ERRO:     begin al = 1; ctf = 1; end
         S_FIM_JOGADA:  begin ztf = 1; zt = 1; end
         S_PROX_JOGADA: begin cc = 1; zm = 1; end
         S_PROX_RODADA: ccr = 1;
         S_GANHOU:      begin pr = 1; g = 1; end
         S_PERDEU:      begin pr = 1; p = 1; end
         S_TIMEOUT:     begin pr = 1; tmo = 1; end
         default: ;
      endcase
      return {zc, cc, zcr, ccr, zr, rr, ztf, ctf, zt, ct, zm, cm, lm, al, to, re, pr, g, p, tmo};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clr_pulses();
      iniciar = 0; cancela = 0; nota_feita = 0; enderecoIgualRodada = 0; fimTF = 0;
      fimTempo = 0; fimCR = 0; fim_musica = 0; press_enter = 0;
   endtask

   // inputs already driven; push expectation, clock once, pop and compare
   task automatic tick(input string tag, input int st, input int errs);
      exp_t e;
      e.tag = tag; e.st = st; e.errs = errs;
      sb.push_back(e);
      @(posedge clock); #1;
      clr_pulses();
      e = sb.pop_front();
      chk({e.tag, ".estado"}, 32'(db_estado), 32'(e.st));
      chk({e.tag, ".erros"},  32'(erros_cnt), 32'(e.errs));
      chk({e.tag, ".saidas"}, 32'(outs),      32'(exp_outs(e.st)));
   endtask

   task automatic inicia(input int errs_before);
      iniciar = 1;
      tick("iniciar", S_PREPARA, errs_before);
      tick("prepara", S_IR, 0);
      tick("ini_rodada", S_MOSTRA, 0);
   endtask

   // from MOSTRA, show notes 0..r and arrive in ESPERA_JOGADA
   task automatic mostra_rodada(input int r, input int errs);
      for (int k = 0; k <= r; k++) begin
         fimTF = 1;
         tick("mostra", S_FIM_MOSTRA, errs);
         enderecoIgualRodada = (k == r);
         tick("fim_mostra", (k == r) ? S_IJ : S_PROX_MOSTRA, errs);
         if (k < r) tick("prox_mostra", S_MOSTRA, errs);
      end
      tick("ini_jogada", S_ESPERA, errs);
   endtask

   // from ESPERA_JOGADA, play one note and check the verdict
   task automatic jogada(input bit nc, input bit tc, input bit ct, input int errs, input int res);
      nota_correta = nc; tempo_correto = tc; checa_tempo = ct; nota_feita = 1;
      tick("espera", S_REGISTRA, errs);
      tick("registra", S_COMPARA, errs);
      tick("compara", res, (res == S_FB_OK) ? errs : errs + 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_cr, base_m;
      // reset state
      #2;
      chk("reset.estado", 32'(db_estado), 0);
      chk("reset.saidas", 32'(outs), 0);
      chk("reset.erros",  32'(erros_cnt), 0);
      repeat (2) @(negedge clock);
      reset = 0;
      tick("idle", S_INICIAL, 0);

      // --- win: 3 notes, song ends at round 2, all notes right
      inicia(0);
      iniciar = 1;
      tick("iniciar_ignorado", S_MOSTRA, 0);
      base_cr = ncr; base_m = nmostra;
      for (int r = 0; r <= 2; r++) begin
         mostra_rodada(r, 0);
         for (int k = 0; k <= r; k++) begin
            jogada(1, 1, 0, 0, S_FB_OK);
            fimTF = 1;
            tick("fb_ok", S_FIM_JOGADA, 0);
            enderecoIgualRodada = (k == r);
            tick("fim_jogada", (k == r) ? S_FIM_RODADA : S_PROX_JOGADA, 0);
            if (k < r) tick("prox_jogada", S_ESPERA, 0);
         end
         fim_musica = (r == 2);
         tick("fim_rodada", (r == 2) ? S_GANHOU : S_PROX_RODADA, 0);
         if (r < 2) begin
            tick("prox_rodada", S_IR, 0);
            tick("ini_rodada", S_MOSTRA, 0);
         end
      end
      chk("ganhou.contaCR_pulsos", 32'(ncr - base_cr), 2);
      chk("ganhou.notas_mostradas", 32'(nmostra - base_m), 6);
      tick("ganhou_espera", S_GANHOU, 0);
      press_enter = 1;
      tick("ganhou_enter", S_INICIAL, 0);

      // --- lose: three wrong notes in round 0, round replayed each time
      inicia(0);
      base_cr = ncr;
      mostra_rodada(0, 0);
      jogada(0, 1, 0, 0, S_FB_ERRO);
      fimTF = 1;
      tick("fb_erro1", S_IR, 1);
      tick("replay1", S_MOSTRA, 1);
      mostra_rodada(0, 1);
      jogada(0, 1, 0, 1, S_FB_ERRO);
      nota_feita = 1; fimTF = 1;
      tick("fb_erro_tecla", S_FB_ERRO, 2);
      fimTF = 1;
      tick("fb_erro2", S_IR, 2);
      tick("replay2", S_MOSTRA, 2);
      mostra_rodada(0, 2);
      jogada(0, 1, 0, 2, S_PERDEU);
      chk("perdeu.mesma_rodada", 32'(ncr - base_cr), 0);
      press_enter = 1;
      tick("perdeu_enter", S_INICIAL, 3);

      // --- tempo check on, then off
      inicia(3);
      mostra_rodada(0, 0);
      jogada(1, 0, 1, 0, S_FB_ERRO);
      fimTF = 1;
      tick("fb_erro_tempo", S_IR, 1);
      tick("replay_tempo", S_MOSTRA, 1);
      mostra_rodada(0, 1);
      jogada(1, 0, 0, 1, S_FB_OK);
      nota_feita = 1; fimTF = 1;
      tick("tecla_presa", S_FB_OK, 1);
      nota_feita = 1;
      tick("tecla_presa2", S_FB_OK, 1);
      fimTF = 1;
      tick("tecla_solta", S_FIM_JOGADA, 1);
      enderecoIgualRodada = 1;
      tick("fim_jogada", S_FIM_RODADA, 1);
      fimCR = 1;
      tick("fimCR", S_GANHOU, 1);
      press_enter = 1;
      tick("enter", S_INICIAL, 1);

      // --- timeout, and simultaneous key + time limit
      inicia(1);
      mostra_rodada(0, 0);
      tick("espera_ociosa", S_ESPERA, 0);
      fimTempo = 1;
      tick("fimTempo", S_TIMEOUT, 0);
      tick("timeout_espera", S_TIMEOUT, 0);
      press_enter = 1;
      tick("timeout_enter", S_INICIAL, 0);
      inicia(0);
      mostra_rodada(0, 0);
      nota_feita = 1; fimTempo = 1;
      tick("tecla_e_tempo", S_REGISTRA, 0);
      cancela = 1;
      tick("cancela_registra", S_INICIAL, 0);

      // --- cancela in ESPERA_JOGADA beats a keypress and keeps the error count
      inicia(0);
      mostra_rodada(0, 0);
      jogada(0, 1, 0, 0, S_FB_ERRO);
      fimTF = 1;
      tick("fb_erro", S_IR, 1);
      tick("replay", S_MOSTRA, 1);
      mostra_rodada(0, 1);
      cancela = 1; nota_feita = 1;
      tick("cancela_espera", S_INICIAL, 1);

      // --- asynchronous reset mid-MOSTRA with a non-zero error count
      inicia(1);
      mostra_rodada(0, 0);
      jogada(0, 1, 0, 0, S_FB_ERRO);
      fimTF = 1;
      tick("fb_erro_r", S_IR, 1);
      tick("mostra_r", S_MOSTRA, 1);
      #2 reset = 1;
      #1;
      chk("reset_async.estado", 32'(db_estado), 0);
      chk("reset_async.saidas", 32'(outs), 0);
      chk("reset_async.erros",  32'(erros_cnt), 0);
      @(negedge clock);
      reset = 0;
      tick("pos_reset", S_INICIAL, 0);
      chk("scoreboard_vazio", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
